// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI read-path arbiter.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_DATA
    } arb_state_t;

    localparam logic M0_IDX = 1'b0;
    localparam logic M1_IDX = 1'b1;

endpackage : axi_arb_pkg

// File: rtl/ar_arbiter_ctrl_rr_pick2.sv
// Combinational two-way round-robin picker: a lone request wins outright,
// a tie goes to the master that was not served last.
module rr_pick2
    import axi_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_idx,
    output logic       o_gnt_valid,
    output logic       o_gnt_idx
);

    // Pick a winner from the current request pair.
    always_comb begin
        o_gnt_valid = |i_req;
        o_gnt_idx   = M0_IDX;
        if (i_req == 2'b11) begin
            o_gnt_idx = ~i_last_idx;
        end else if (i_req[1]) begin
            o_gnt_idx = M1_IDX;
        end
    end

endmodule : rr_pick2

// File: rtl/ar_arbiter_ctrl.sv
// Read-path sequencing arbiter: grants one master through the AR handshake
// and the whole R burst, releasing on RLAST or on a watchdog timeout.
module ar_arbiter_ctrl
    import axi_arb_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int TO_W    = $clog2(TIMEOUT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ARVALID_M0,
    input  logic       ARVALID_M1,
    input  logic       AR_hs,
    input  logic       R_hs,
    input  logic       RLAST,
    output logic       grant_M0,
    output logic       grant_M1,
    output logic       master_idx,
    output logic       busy,
    output logic [3:0] beat_cnt,
    output logic       timeout
);

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic            r_idx;
    logic            w_idx_nxt;
    logic            r_last_idx;
    logic            w_last_idx_nxt;
    logic [TO_W-1:0] r_wd;
    logic [TO_W-1:0] w_wd_nxt;
    logic [3:0]      r_beat;
    logic [3:0]      w_beat_nxt;
    logic            r_timeout;
    logic            w_timeout_nxt;
    logic            r_grant_m0;
    logic            r_grant_m1;
    logic            r_busy;
    logic            w_gnt_valid;
    logic            w_gnt_idx;
    logic            w_wd_expired;
    logic            w_done;

    rr_pick2 u_pick (
        .i_req       ({ARVALID_M1, ARVALID_M0}),
        .i_last_idx  (r_last_idx),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_idx   (w_gnt_idx)
    );

    assign w_wd_expired = (r_wd == WD_LAST);
    assign w_done       = R_hs && RLAST;

    // Next-state logic: grant in IDLE, hold through ADDR/DATA, release on
    // completion (which takes precedence) or watchdog expiry.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_last_idx_nxt = r_last_idx;
        w_wd_nxt       = r_wd;
        w_beat_nxt     = r_beat;
        w_timeout_nxt  = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_gnt_valid) begin
                    w_state_nxt = ARB_ADDR;
                    w_idx_nxt   = w_gnt_idx;
                    w_wd_nxt    = '0;
                end
            end
            ARB_ADDR: begin
                if (AR_hs) begin
                    w_beat_nxt = 4'd0;
                end
                if (w_wd_expired) begin
                    w_state_nxt    = ARB_IDLE;
                    w_timeout_nxt  = 1'b1;
                    w_last_idx_nxt = r_idx;
                    w_idx_nxt      = M0_IDX;
                end else begin
                    w_wd_nxt = r_wd + 1'b1;
                    if (AR_hs) begin
                        w_state_nxt = ARB_DATA;
                    end
                end
            end
            ARB_DATA: begin
                if (R_hs) begin
                    w_beat_nxt = r_beat + 4'd1;
                end
                if (w_done) begin
                    w_state_nxt    = ARB_IDLE;
                    w_last_idx_nxt = r_idx;
                    w_idx_nxt      = M0_IDX;
                end else if (w_wd_expired) begin
                    w_state_nxt    = ARB_IDLE;
                    w_timeout_nxt  = 1'b1;
                    w_last_idx_nxt = r_idx;
                    w_idx_nxt      = M0_IDX;
                end else begin
                    w_wd_nxt = r_wd + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_idx_nxt   = M0_IDX;
            end
        endcase
    end

    // State, watchdog, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_idx      <= M0_IDX;
            r_last_idx <= M1_IDX;
            r_wd       <= '0;
            r_beat     <= 4'd0;
            r_timeout  <= 1'b0;
            r_grant_m0 <= 1'b0;
            r_grant_m1 <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_last_idx <= w_last_idx_nxt;
            r_wd       <= w_wd_nxt;
            r_beat     <= w_beat_nxt;
            r_timeout  <= w_timeout_nxt;
            r_grant_m0 <= (w_state_nxt != ARB_IDLE) && (w_idx_nxt == M0_IDX);
            r_grant_m1 <= (w_state_nxt != ARB_IDLE) && (w_idx_nxt == M1_IDX);
            r_busy     <= (w_state_nxt != ARB_IDLE);
        end
    end

    assign grant_M0   = r_grant_m0;
    assign grant_M1   = r_grant_m1;
    assign master_idx = r_idx;
    assign busy       = r_busy;
    assign beat_cnt   = r_beat;
    assign timeout    = r_timeout;

endmodule : ar_arbiter_ctrl

// File: doc/ar_arbiter_ctrl.md
# ar_arbiter_ctrl

Sequencing arbiter for the shared AXI read path between master 0 (instruction side) and master 1 (data side). It grants exactly one master at a time and holds that grant through the address handshake and the complete read burst. It releases on the last data beat or on a watchdog timeout. Priority is round-robin, so neither master can starve the other. Its grant outputs drive the AR/R channel muxes in the bus interconnect.

## Interface
Parameters:
- TIMEOUT, 256: max cycles a grant may be held (ADDR+DATA) before forced release; must be ≥ 2.
- TO_W, $clog2(TIMEOUT): watchdog counter width (derived, do not override).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset is synchronous and active-high.
- ARVALID_M0  in  1  master 0 read-address request.
- ARVALID_M1  in  1  master 1 read-address request.
- AR_hs  in  1  address handshake done at slave side (ARVALID_Sx && ARREADY_Sx of routed slave).
- R_hs  in  1  read-data beat accepted by granted master (RVALID && RREADY).
- RLAST  in  1  last-beat flag of current R beat.
- grant_M0  out  1  master 0 owns read path.
- grant_M1  out  1  master 1 owns read path.
- master_idx  out  1  index of granted master; 0 when idle.
- busy  out  1  a grant is active (state ≠ IDLE).
- beat_cnt  out  4  data beats accepted in current burst.
- timeout  out  1  one-cycle pulse on watchdog release.

## Operation
- States: IDLE, ADDR, DATA.
- Register last_idx records the last served master; reset value 1, so M0 wins the first tie.
- IDLE:
  - No grants asserted.
  - Only one ARVALID high: grant that master.
  - Both high: grant !last_idx.
  - Neither high: stay in IDLE.
  - On grant: next state ADDR, grant_Mx=1, master_idx set, watchdog cleared.
- ADDR:
  - Grant is held unconditionally, even if the master drops ARVALID.
  - AR_hs → DATA, beat_cnt←0.
  - R_hs is ignored in this state.
- DATA:
  - Each R_hs increments beat_cnt (mod 16).
  - R_hs && RLAST → IDLE; last_idx←master_idx; grants and master_idx drop.
  - AR_hs is ignored in this state.
- Watchdog:
  - Counts every cycle in ADDR or DATA.
  - On reaching TIMEOUT-1 without completion: → IDLE, timeout=1 for one cycle, last_idx←master_idx.
  - If completion (R_hs&&RLAST) and timeout coincide: normal completion, timeout stays 0.
- AR_hs or R_hs in IDLE: ignored, no state change.
- Grants are one-hot or zero at all times; grant_M0 && grant_M1 never asserted together.

## Timing
- All outputs are registered.
- Reset values: grant_M0=0, grant_M1=0, master_idx=0, busy=0, beat_cnt=0, timeout=0; state=IDLE, last_idx=1, watchdog=0.
- rst mid-burst: next edge forces reset values regardless of inputs.
- Request latency: ARVALID sampled high in IDLE at edge E → grant visible after E (one cycle).
- Release: completing beat at edge E → IDLE after E.
- Re-grant: earliest re-grant after E+1. Minimum gap between bursts is one idle cycle.
- beat_cnt updates on the same edge as the beat. It holds its value in IDLE until the next AR_hs.
- Worst-case wait for a continuously requesting master: one full burst of the other master plus 2 cycles.

## Structure
- Package axi_arb_pkg holds:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_DATA} arb_state_t;
  - localparam M0_IDX=1'b0 and M1_IDX=1'b1.
- Sub-module rr_pick2: combinational 2-way round-robin picker (req[1:0], last_idx → gnt_valid, gnt_idx). The top level holds the FSM, watchdog, beat counter and output registers.

## Test plan
- After reset, ARVALID_M0=ARVALID_M1=1 → grant_M0=1 next cycle; AR_hs, then 4 R_hs with RLAST on the 4th → beat_cnt=4, grants drop. Requests still held → grant_M1=1 two cycles after the last beat.
- Only ARVALID_M1=1 while last_idx=1 → grant_M1=1 anyway. Priority applies only to ties.
- ARLEN=15 burst: 16 R_hs → beat_cnt wraps to 0 on the 16th beat; release on RLAST.
- TIMEOUT=8, grant M0 then no AR_hs → after 8 granted cycles, timeout pulses once, grant_M0=0. Next tie goes to M1.
- R_hs&&RLAST on the same cycle the watchdog expires → timeout=0, normal release.
- rst asserted in DATA with beat_cnt=3 → next cycle all outputs at reset values. The first tie after reset is granted to M0.
